// File: rtl/fp_cvt_pipe.sv
// Two-stage IEEE-style format converter (widen or narrow) behind a valid/ready pipe.
// S1 unpacks, classifies and normalises denormals; S2 rebiases, rounds and packs.
module fp_cvt_pipe #(
    parameter int FPWID_I = 96,
    parameter int EXPW_I  = 15,
    parameter int FPWID_O = 128,
    parameter int EXPW_O  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [FPWID_I-1:0] i,
    input  logic [2:0]         rm,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [FPWID_O-1:0] o,
    output logic [4:0]         o_flags
);
    localparam int FRACW_I = FPWID_I - EXPW_I - 1;
    localparam int FRACW_O = FPWID_O - EXPW_O - 1;
    localparam int BIAS_I  = 2**(EXPW_I-1) - 1;
    localparam int BIAS_O  = 2**(EXPW_O-1) - 1;
    localparam int W       = ((EXPW_I > EXPW_O) ? EXPW_I : EXPW_O) + 2;
    localparam int XW      = (FRACW_I > FRACW_O + 2) ? FRACW_I : FRACW_O + 2;
    localparam int MW      = FRACW_O + 3;
    localparam int LZW     = $clog2(FRACW_I + 1);
    localparam int SHW     = $clog2(MW);

    localparam logic signed [W-1:0] BIAS_I_S = W'(BIAS_I);
    localparam logic signed [W-1:0] BIAS_O_S = W'(BIAS_O);
    localparam logic signed [W-1:0] EMAX_S   = W'(2**EXPW_O - 1);
    localparam logic signed [W-1:0] SHMAX_S  = W'(MW - 1);
    localparam logic signed [W-1:0] ONE_S    = W'(1);

    typedef enum logic [2:0] {C_FIN, C_ZERO, C_INF, C_QNAN, C_SNAN} cls_t;

    function automatic logic [LZW-1:0] lzc(input logic [FRACW_I-1:0] f);
        lzc = '0;
        for (int k = 0; k < FRACW_I; k++)
            if (f[k]) lzc = LZW'(FRACW_I - 1 - k);
    endfunction

    logic [2:1]          vld_pipe;
    logic                s1_sign;
    cls_t                s1_cls;
    logic signed [W-1:0] s1_exp;
    logic [FRACW_I-1:0]  s1_frac;
    logic [2:0]          s1_rm;
    logic                s1_load, s2_take;

    assign i_ready = !vld_pipe[2] | o_ready | !vld_pipe[1];
    assign s1_load = i_valid & i_ready;
    assign s2_take = vld_pipe[1] & (!vld_pipe[2] | o_ready);
    assign o_valid = vld_pipe[2];

    // ---- S1: classify; denormals get their leading one moved to the hidden position
    logic                in_sign;
    logic [EXPW_I-1:0]   in_exp;
    logic [FRACW_I-1:0]  in_frac, nrm_frac;
    logic [LZW-1:0]      lz;
    logic signed [W-1:0] unb_exp;
    cls_t                in_cls;

    always_comb begin
        in_sign  = i[FPWID_I-1];
        in_exp   = i[FPWID_I-2 -: EXPW_I];
        in_frac  = i[FRACW_I-1:0];
        lz       = lzc(in_frac);
        nrm_frac = in_frac;
        unb_exp  = $signed(W'(in_exp)) - BIAS_I_S;
        in_cls   = C_FIN;
        if (&in_exp)
            in_cls = (in_frac == '0) ? C_INF : (in_frac[FRACW_I-1] ? C_QNAN : C_SNAN);
        else if (in_exp == '0) begin
            in_cls   = (in_frac == '0) ? C_ZERO : C_FIN;
            nrm_frac = in_frac << (lz + 1'b1);
            unb_exp  = -BIAS_I_S - $signed(W'(lz));
        end
    end

    // ---- S2: align fraction, denormalise if needed, round, pack
    logic [XW-1:0]       ext;
    logic                lo_sticky, g, s, inc, inexact, ovf, tiny, to_inf;
    logic [MW-1:0]       mant, mant_sh;
    logic [SHW-1:0]      sh;
    logic signed [W-1:0] out_exp, pre_exp, fin_exp, den_dist;
    logic [FRACW_O+1:0]  rnd;
    logic [FPWID_O-1:0]  res;
    logic [4:0]          flags;

    always_comb begin
        ext = '0;
        ext[XW-1 -: FRACW_I] = s1_frac;
        lo_sticky = |(ext & ({XW{1'b1}} >> (FRACW_O + 2)));
        mant     = {1'b1, ext[XW-1 -: FRACW_O+2]};
        out_exp  = s1_exp + BIAS_O_S;
        den_dist = ONE_S - out_exp;
        pre_exp  = out_exp;
        sh       = '0;
        if (out_exp < ONE_S) begin
            pre_exp = '0;
            sh = (den_dist > SHMAX_S) ? SHW'(MW - 1) : SHW'(den_dist);
        end
        mant_sh = mant >> sh;
        g       = mant_sh[1];
        s       = mant_sh[0] | lo_sticky | (|(mant & ~({MW{1'b1}} << sh)));
        inexact = g | s;
        case (s1_rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = s1_sign & inexact;
            3'd3:    inc = !s1_sign & inexact;
            3'd4:    inc = g;
            default: inc = g & (s | mant_sh[2]);
        endcase
        rnd = {1'b0, mant_sh[MW-1:2]} + {{(FRACW_O+1){1'b0}}, inc};
        // a denormal that rounds into the hidden bit becomes the minimum normal
        if (pre_exp == '0) fin_exp = $signed(W'(rnd[FRACW_O]));
        else               fin_exp = pre_exp + $signed(W'(rnd[FRACW_O+1]));
        ovf    = fin_exp >= EMAX_S;
        tiny   = fin_exp == '0;
        to_inf = (s1_rm == 3'd1) ? 1'b0 : (s1_rm == 3'd2) ? s1_sign :
                 (s1_rm == 3'd3) ? !s1_sign : 1'b1;
        res   = {s1_sign, fin_exp[EXPW_O-1:0], rnd[FRACW_O-1:0]};
        flags = {3'b000, tiny & inexact, inexact};
        case (s1_cls)
            C_ZERO: begin
                res   = {s1_sign, {(FPWID_O-1){1'b0}}};
                flags = '0;
            end
            C_INF: begin
                res   = {s1_sign, {EXPW_O{1'b1}}, {FRACW_O{1'b0}}};
                flags = '0;
            end
            C_QNAN, C_SNAN: begin
                res   = {s1_sign, {EXPW_O{1'b1}}, 1'b1, ext[XW-2 -: FRACW_O-1]};
                flags = {s1_cls == C_SNAN, 4'b0000};
            end
            default: if (ovf) begin
                res   = to_inf ? {s1_sign, {EXPW_O{1'b1}}, {FRACW_O{1'b0}}}
                               : {s1_sign, {(EXPW_O-1){1'b1}}, 1'b0, {FRACW_O{1'b1}}};
                flags = 5'b00101;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_sign  <= 1'b0;
            s1_cls   <= C_ZERO;
            s1_exp   <= '0;
            s1_frac  <= '0;
            s1_rm    <= '0;
            o        <= '0;
            o_flags  <= '0;
        end else begin
            if (s1_load) begin
                vld_pipe[1] <= 1'b1;
                s1_sign     <= in_sign;
                s1_cls      <= in_cls;
                s1_exp      <= unb_exp;
                s1_frac     <= nrm_frac;
                s1_rm       <= (rm > 3'd4) ? 3'd0 : rm;
            end else if (s2_take) begin
                vld_pipe[1] <= 1'b0;
            end
            if (s2_take) begin
                vld_pipe[2] <= 1'b1;
                o           <= res;
                o_flags     <= flags;
            end else if (o_ready) begin
                vld_pipe[2] <= 1'b0;
            end
        end
    end
endmodule
